// File: rtl/fifo_21.sv
// First-word-fall-through FIFO: the head word sits registered on dout_o with valid_o,
// and a one-cycle rd_en_i pulse pops it.
module fifo_21 #(
    parameter int unsigned WIDTH  = 21,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned W_ADDR = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WIDTH-1:0]  din_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    output logic [WIDTH-1:0]  dout_o,
    output logic              valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [W_ADDR:0]   data_count_o
);

    localparam int unsigned CW = W_ADDR + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [W_ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [W_ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [W_ADDR:0]   count_q, count_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              full;
    logic              push;
    logic              pop;

    assign full = (count_q == CW'(DEPTH));

    always_comb begin
        pop      = rd_en_i && valid_q;
        push     = wr_en_i && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + W_ADDR'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + W_ADDR'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        valid_d = (count_d != '0);
        dout_d  = dout_q;
        // The new head may be the word being written this very cycle.
        if (valid_d) begin
            dout_d = (push && (wr_ptr_q == rd_ptr_d)) ? din_i : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o       = dout_q;
    assign valid_o      = valid_q;
    assign full_o       = full;
    assign empty_o      = !valid_q;
    assign data_count_o = count_q;

endmodule

// File: tb/tb_fifo_21.sv
// Directed bench for fifo_21: a queue scoreboard tracks expected contents and is compared
// against the DUT after every clock edge.
module tb_fifo_21;

    localparam int unsigned WIDTH = 21;
    localparam int unsigned DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             full;
    logic             empty;
    logic [4:0]       data_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH-1:0] sb[$];

    fifo_21 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .W_ADDR(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .din_i        (din),
        .wr_en_i      (wr_en),
        .rd_en_i      (rd_en),
        .dout_o       (dout),
        .valid_o      (valid),
        .full_o       (full),
        .empty_o      (empty),
        .data_count_o (data_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(data_count), 32'(sb.size()));
        chk({tag, ".valid"}, 32'(valid), 32'(sb.size() != 0));
        chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(sb.size() == DEPTH));
        if (sb.size() != 0) chk({tag, ".dout"}, 32'(dout), 32'(sb[0]));
    endtask

    // One clock: drive inputs, advance the scoreboard, then compare after the edge.
    task automatic cycle(input string tag, input bit we, input logic [WIDTH-1:0] d,
                         input bit re);
        bit do_pop;
        bit do_push;
        wr_en   = we;
        din     = d;
        rd_en   = re;
        do_pop  = re && (sb.size() != 0);
        do_push = we && ((sb.size() < DEPTH) || do_pop);
        if (do_pop) begin
            chk({tag, ".popped"}, 32'(dout), 32'(sb[0]));
            void'(sb.pop_front());
        end
        if (do_push) sb.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_state(tag);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        int pushed;
        int guard;

        // Reset and idle
        do_reset();
        chk("rst.dout", 32'(dout), 32'h0);
        chk_state("rst");
        for (int i = 0; i < 3; i++) cycle("idle", 1'b0, '0, 1'b0);
        chk("idle.dout", 32'(dout), 32'h0);

        // Single word held for several cycles, then popped
        cycle("push_abc", 1'b1, 21'h00ABC, 1'b0);
        for (int i = 0; i < 5; i++) cycle("hold_abc", 1'b0, '0, 1'b0);
        cycle("pop_abc", 1'b0, '0, 1'b1);

        // Fill, overflow, drain
        for (int i = 1; i <= 16; i++) cycle("fill", 1'b1, 21'(i), 1'b0);
        cycle("overflow", 1'b1, 21'd17, 1'b0);
        for (int i = 0; i < 16; i++) cycle("drain", 1'b0, '0, 1'b1);

        // Simultaneous push/pop at one word and at full
        cycle("one_push", 1'b1, 21'd5, 1'b0);
        cycle("one_rw", 1'b1, 21'd6, 1'b1);
        chk("one_rw.head6", 32'(dout), 32'd6);
        cycle("one_pop", 1'b0, '0, 1'b1);
        for (int i = 0; i < 16; i++) cycle("refill", 1'b1, 21'(100 + i), 1'b0);
        for (int i = 0; i < 4; i++) cycle("full_rw", 1'b1, 21'(200 + i), 1'b1);
        for (int i = 0; i < 16; i++) cycle("full_drain", 1'b0, '0, 1'b1);

        // Random interleaving across pointer wrap
        pushed = 0;
        guard  = 0;
        while ((pushed < 40 || sb.size() != 0) && guard < 1000) begin
            bit we;
            bit re;
            we = (pushed < 40) && ($urandom_range(0, 1) == 1);
            re = ($urandom_range(0, 2) != 0);
            if (we && ((sb.size() < DEPTH) || (re && sb.size() != 0))) pushed++;
            cycle("rand", we, 21'($urandom_range(0, 2097151)), re);
            guard++;
        end
        chk("rand.done", 32'(guard < 1000), 32'd1);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 21'(300 + i), 1'b0);
        do_reset();
        chk_state("mid_rst");
        cycle("post_rst", 1'b1, 21'd7, 1'b0);
        chk("post_rst.dout7", 32'(dout), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
